// File: rtl/gray_roi_downsampler_pkg.sv
// Shared constants and FSM state type for the greyscale ROI downsampler.
// Sizes describe the 224x224 ROI reduced to a 28x28 classifier image.
package gray_roi_downsampler_pkg;

  localparam int GRAY_ROI_SIDE = 224;
  localparam int GRAY_OUT_DIM  = 28;
  localparam int GRAY_OUT_PIX  = 784;
  localparam int GRAY_ACC_W    = 14;
  localparam int GRAY_ADDR_W   = 10;
  localparam int GRAY_COL_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } gray_state_t;

endpackage

// File: rtl/gray_img_ram.sv
// 784x8 simple dual-port image RAM, one write port, registered read.
// Read data is masked to zero until the first clock after reset.
module gray_img_ram
  import gray_roi_downsampler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [GRAY_ADDR_W-1:0] waddr,
  input  logic [7:0]             wdata,
  input  logic [GRAY_ADDR_W-1:0] raddr,
  output logic [7:0]             rdata
);

  logic [7:0] mem [GRAY_OUT_PIX];
  logic [7:0] q;
  logic       live;

  // no reset here so the array and read register map onto a block RAM
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      live <= 1'b0;
    else
      live <= 1'b1;
  end

  assign rdata = live ? q : '0;

endmodule

// File: rtl/gray_roi_downsampler.sv
// Bins a centred ROI of the decimated grey stream into an inverted
// 28x28 image, one frame per start request, read via a sync port.
module gray_roi_downsampler
  import gray_roi_downsampler_pkg::*;
#(
  parameter int ROI_X0   = 48,
  parameter int ROI_Y0   = 8,
  parameter int OUT_DIM  = 28,
  parameter int BIN_LOG2 = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iGrey,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iStart,
  input  logic [9:0]  iRdAddr,
  output logic [7:0]  oRdData,
  output logic        oBusy,
  output logic        oReady,
  output logic        oDone
);

  localparam int SIDE = OUT_DIM << BIN_LOG2;
  localparam int LAST = OUT_DIM * OUT_DIM - 1;

  gray_state_t state, state_nx;

  logic [GRAY_ACC_W-1:0]  acc [OUT_DIM];
  logic [9:0]             dx, dy, rx, ry;
  logic [GRAY_COL_W-1:0]  col, brow;
  logic [7:0]             pix, wdata;
  logic [GRAY_ACC_W-1:0]  sum;
  logic [GRAY_ADDR_W-1:0] waddr;
  logic in_roi, bin_end, sof;
  logic take, we, clr;
  logic ready_q, done_q;
  logic unused_lsb;

  assign dx = iX_Cont[10:1];
  assign dy = iY_Cont[10:1];
  assign rx = dx - 10'(ROI_X0);
  assign ry = dy - 10'(ROI_Y0);

  assign in_roi = (dx >= 10'(ROI_X0)) && (rx < 10'(SIDE))
               && (dy >= 10'(ROI_Y0)) && (ry < 10'(SIDE));

  assign col     = GRAY_COL_W'(rx >> BIN_LOG2);
  assign brow    = GRAY_COL_W'(ry >> BIN_LOG2);
  assign bin_end = (&rx[BIN_LOG2-1:0]) && (&ry[BIN_LOG2-1:0]);
  assign sof     = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);

  assign pix        = iGrey[11:4];
  assign unused_lsb = ^iGrey[3:0];

  // the frame-start pixel that arms capture is itself processed
  assign take = iDVAL && in_roi
             && ((state == CAPTURE) || (state == ARMED && sof));
  assign we   = take && bin_end;
  assign clr  = (state == IDLE && iStart) || (state == CAPTURE && sof);

  assign sum   = acc[col] + GRAY_ACC_W'(pix);
  assign wdata = 8'd255 - 8'(sum >> (2 * BIN_LOG2));
  assign waddr = GRAY_ADDR_W'(brow) * GRAY_ADDR_W'(OUT_DIM)
               + GRAY_ADDR_W'(col);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (iStart) state_nx = ARMED;
      ARMED:   if (sof) state_nx = CAPTURE;
      CAPTURE: if (we && waddr == GRAY_ADDR_W'(LAST)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == DONE);
      if (state == DONE)
        ready_q <= 1'b1;
      else if (state == IDLE && iStart)
        ready_q <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < OUT_DIM; i++)
        acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < OUT_DIM; i++)
        acc[i] <= '0;
    end else if (take) begin
      acc[col] <= bin_end ? '0 : sum;
    end
  end

  gray_img_ram u_ram (
    .clk   (iCLK),
    .rst_n (iRST),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (iRdAddr),
    .rdata (oRdData)
  );

  assign oBusy  = (state == ARMED) || (state == CAPTURE);
  assign oReady = ready_q;
  assign oDone  = done_q;

endmodule

// File: tb/tb_gray_roi_downsampler.sv
// Directed bench for gray_roi_downsampler: sparse/full frames,
// bin and ramp images, restart, ignored start and mid-frame reset.
module tb_gray_roi_downsampler;

  localparam int X0 = 48;
  localparam int Y0 = 8;
  localparam int M_ZERO = 0;
  localparam int M_FULL = 1;
  localparam int M_BIN  = 2;
  localparam int M_RAMP = 3;
  localparam int M_TICK = 4;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [11:0] iGrey;
  logic        iDVAL;
  logic [10:0] iX_Cont;
  logic [10:0] iY_Cont;
  logic        iStart;
  logic [9:0]  iRdAddr;
  logic [7:0]  oRdData;
  logic        oBusy;
  logic        oReady;
  logic        oDone;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  logic [7:0] exp_img [784];

  gray_roi_downsampler dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iGrey   (iGrey),
    .iDVAL   (iDVAL),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iStart  (iStart),
    .iRdAddr (iRdAddr),
    .oRdData (oRdData),
    .oBusy   (oBusy),
    .oReady  (oReady),
    .oDone   (oDone)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oDone === 1'b1) done_cnt++;
    if (oBusy === 1'b1) busy_cyc++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic pix(input int x, input int y,
                     input logic [11:0] g, input logic v);
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iGrey   = g;
    iDVAL   = v;
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [7:0] pix_val(int mode, int rx, int ry);
    case (mode)
      M_FULL: return 8'd255;
      M_BIN:
        if (rx / 8 == 5 && ry / 8 == 3)
          return (ry % 8 < 4) ? 8'd200 : 8'd100;
      M_RAMP:
        if (ry / 8 == 0 || ry / 8 == 27)
          return 8'((rx + X0) % 256);
      M_TICK:
        if (rx % 8 == 7 && ry % 8 == 7)
          return 8'd255;
      default: return 8'd0;
    endcase
    return 8'd0;
  endfunction

  // zero pixels add nothing, so only nonzero and bin-closing ones are sent
  task automatic send_frame(input int mode, input int last_ry);
    int n = 0;
    logic [7:0] v;
    pix(0, 0, 12'hFFF, 1'b1);
    for (int c = 0; c < 28; c++)
      pix(2 * (X0 + 8 * c + 7), 2 * (Y0 - 1), 12'hFFF, 1'b1);
    for (int ry = 0; ry <= last_ry; ry++) begin
      if (ry % 8 == 7) begin
        pix(2 * (X0 - 1), 2 * (Y0 + ry), 12'hFFF, 1'b1);
        pix(2 * (X0 + 224), 2 * (Y0 + ry), 12'hFFF, 1'b1);
      end
      for (int rx = 0; rx < 224; rx++) begin
        v = pix_val(mode, rx, ry);
        if (v != 0 || (rx % 8 == 7 && ry % 8 == 7)) begin
          pix(2 * (X0 + rx), 2 * (Y0 + ry), {v, 4'hA}, 1'b1);
          n++;
          if (n % 61 == 0)
            pix(2 * (X0 + rx) + 1, 2 * (Y0 + ry), 12'hFFF, 1'b0);
        end
      end
    end
    if (last_ry == 223)
      for (int c = 0; c < 28; c++)
        pix(2 * (X0 + 8 * c + 7), 2 * (Y0 + 224), 12'hFFF, 1'b1);
    iDVAL = 1'b0;
    iGrey = '0;
  endtask

  task automatic start();
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    chk("busy_on", oBusy, 1);
    chk("ready_clr", oReady, 0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (oReady !== 1'b1 && k < 20) begin
      @(posedge iCLK);
      #1;
      k++;
    end
    chk("ready_set", oReady, 1);
    repeat (3) @(posedge iCLK);
    #1;
    chk("done_low", oDone, 0);
    chk("busy_off", oBusy, 0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < 784; a++)
      exp_img[a] = v;
  endtask

  task automatic read_all(input string tag);
    iRdAddr = '0;
    for (int a = 0; a < 784; a++) begin
      @(posedge iCLK);
      #1;
      chk($sformatf("%s[%0d]", tag, a), oRdData, exp_img[a]);
      if (a < 783)
        iRdAddr = 10'(a + 1);
    end
  endtask

  initial begin
    int d0;
    int b0;
    int s;
    iRST = 1'b0;
    iGrey = '0;
    iDVAL = 1'b0;
    iX_Cont = '0;
    iY_Cont = '0;
    iStart = 1'b0;
    iRdAddr = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_rd", oRdData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_ready", oReady, 0);
    chk("rst_done", oDone, 0);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    d0 = done_cnt;
    start();
    send_frame(M_ZERO, 223);
    wait_ready();
    chk("zero_done", done_cnt - d0, 1);
    fill(8'd255);
    read_all("zero");

    d0 = done_cnt;
    b0 = busy_cyc;
    repeat (10) send_frame(M_TICK, 223);
    chk("idle_busy", busy_cyc - b0, 0);
    chk("idle_done", done_cnt - d0, 0);
    chk("idle_ready", oReady, 1);
    read_all("idle");

    d0 = done_cnt;
    start();
    send_frame(M_FULL, 223);
    wait_ready();
    chk("full_done", done_cnt - d0, 1);
    fill(8'd0);
    read_all("full");
    chk("full_ready", oReady, 1);

    d0 = done_cnt;
    start();
    send_frame(M_FULL, 3);
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    chk("ign_busy", oBusy, 1);
    send_frame(M_ZERO, 223);
    wait_ready();
    chk("restart_done", done_cnt - d0, 1);
    fill(8'd255);
    read_all("restart");

    d0 = done_cnt;
    start();
    send_frame(M_RAMP, 223);
    wait_ready();
    chk("ramp_done", done_cnt - d0, 1);
    fill(8'd255);
    for (int c = 0; c < 28; c++) begin
      s = 0;
      for (int k = 0; k < 8; k++)
        s += (X0 + 8 * c + k) % 256;
      exp_img[c] = 8'(255 - s / 8);
      exp_img[27 * 28 + c] = 8'(255 - s / 8);
    end
    read_all("ramp");

    start();
    send_frame(M_TICK, 92);
    iRST = 1'b0;
    #1;
    chk("abort_busy", oBusy, 0);
    chk("abort_ready", oReady, 0);
    chk("abort_done", oDone, 0);
    chk("abort_rd", oRdData, 0);
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    d0 = done_cnt;
    start();
    send_frame(M_BIN, 223);
    wait_ready();
    chk("bin_done", done_cnt - d0, 1);
    fill(8'd255);
    exp_img[89] = 8'd105;
    read_all("bin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
